// File: rtl/p2s_pkg.sv
// p2s_pkg: shared definitions for the parallel-to-serial shift-register driver.
//   state_t        - FSM state encoding (3 bits)
//   bit_cnt_width  - width of the per-word bit counter for a given word size
package p2s_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LATCH    = 3'd3,
    ST_CLEAR    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Counter must index 0..data_bits-1; never narrower than one bit.
  function automatic int bit_cnt_width(input int data_bits);
    return (data_bits < 2) ? 1 : $clog2(data_bits);
  endfunction

endpackage

// File: rtl/p2s_phase_timer.sv
// p2s_phase_timer: per-phase down-counter for the serializer FSM.
//   clk       in  system clock
//   rstn      in  synchronous active-low reset
//   load      in  high in the cycle before a new phase begins (state change)
//   phase_end out high in the last cycle of the current phase
// Each phase lasts CLK_DIV cycles: the counter is reloaded with CLK_DIV-1 on
// entry and phase_end is asserted once it reaches zero.
module p2s_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  output logic phase_end
);

  localparam int TW = $clog2(CLK_DIV + 1);
  localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign phase_end = (cnt == '0);

endmodule

// File: rtl/p2s_serializer.sv
// p2s_serializer: parallel-to-serial driver for daisy-chained shift registers
// (74HC595 style). Shifts a captured word out on a divided, registered s_clk,
// then pulses the storage latch and signals done. Also issues chain clears.
//   clk     in  system clock
//   rstn    in  synchronous active-low reset
//   start   in  send request, level-sampled in IDLE
//   clr     in  chain-clear request, level-sampled in IDLE (wins over start)
//   pdata   in  word to send, sampled only in the acceptance cycle
//   busy    out transfer or clear in progress
//   done    out one-cycle completion pulse
//   s_clk   out serial shift clock
//   s_data  out serial data
//   s_latch out storage-register latch strobe
//   s_clrn  out active-low chain clear
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start or clr
// SHIFT_LO | s_clk low, current bit presented on s_data
// SHIFT_HI | s_clk high, chain shifts on the rising edge
// LATCH    | s_latch high, transfers chain contents to storage outputs
// CLEAR    | s_clrn low, resets the chain
// DONE     | one-cycle done pulse, then back to IDLE
module p2s_serializer
  import p2s_pkg::*;
#(
  parameter int DATA_BITS = 64,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 clr,
  input  logic [DATA_BITS-1:0] pdata,
  output logic                 busy,
  output logic                 done,
  output logic                 s_clk,
  output logic                 s_data,
  output logic                 s_latch,
  output logic                 s_clrn
);

  localparam int CW = bit_cnt_width(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  state_t                 state, state_nxt;
  logic                   phase_end;
  logic                   phase_load;
  logic                   accept;
  logic                   advance;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   shreg_shifted;
  logic [CW-1:0]          bit_cnt;
  logic                   first_of_pdata;
  logic                   first_of_shifted;

  p2s_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .load      (phase_load),
    .phase_end (phase_end)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (clr)        state_nxt = ST_CLEAR;
        else if (start) state_nxt = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: if (phase_end) state_nxt = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (phase_end) state_nxt = (bit_cnt == LAST_BIT) ? ST_LATCH : ST_SHIFT_LO;
      end
      ST_LATCH:    if (phase_end) state_nxt = ST_DONE;
      ST_CLEAR:    if (phase_end) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Every state change starts a fresh phase, so the timer reloads on it.
  assign phase_load = (state_nxt != state);
  assign accept     = (state == ST_IDLE) && start && !clr;
  assign advance    = (state == ST_SHIFT_HI) && (state_nxt == ST_SHIFT_LO);

  always_comb begin
    shreg_shifted    = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
    first_of_pdata   = (MSB_FIRST != 0) ? pdata[DATA_BITS-1] : pdata[0];
    first_of_shifted = (MSB_FIRST != 0) ? shreg_shifted[DATA_BITS-1] : shreg_shifted[0];
  end

  // Outputs are registered from the next state so every pin is a flop and
  // changes exactly on state entry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_clk   <= 1'b0;
      s_data  <= 1'b0;
      s_latch <= 1'b0;
      s_clrn  <= 1'b1;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt == ST_SHIFT_LO) || (state_nxt == ST_SHIFT_HI) ||
                 (state_nxt == ST_LATCH)    || (state_nxt == ST_CLEAR);
      done    <= (state_nxt == ST_DONE);
      s_clk   <= (state_nxt == ST_SHIFT_HI);
      s_latch <= (state_nxt == ST_LATCH);
      s_clrn  <= (state_nxt != ST_CLEAR);

      if (accept) begin
        shreg   <= pdata;
        bit_cnt <= '0;
        s_data  <= first_of_pdata;
      end else if (advance) begin
        shreg   <= shreg_shifted;
        bit_cnt <= bit_cnt + CW'(1);
        s_data  <= first_of_shifted;
      end else if (state_nxt == ST_DONE) begin
        s_data  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
module tb_p2s_serializer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  start_v, clr_v;
  logic [2:0]  busy_v, done_v, s_clk_v, s_data_v, s_latch_v, s_clrn_v;
  logic [7:0]  pdata_a, pdata_b;
  logic [63:0] pdata_c;

  always #5 clk = ~clk;

  // Instance 0: 8 bits, div 1, LSB first. Instance 1: 8 bits, div 3, MSB first.
  // Instance 2: 64 bits, div 2, LSB first.
  p2s_serializer #(.DATA_BITS(8), .CLK_DIV(1), .MSB_FIRST(0)) u_a (
    .clk(clk), .rstn(rstn), .start(start_v[0]), .clr(clr_v[0]), .pdata(pdata_a),
    .busy(busy_v[0]), .done(done_v[0]), .s_clk(s_clk_v[0]), .s_data(s_data_v[0]),
    .s_latch(s_latch_v[0]), .s_clrn(s_clrn_v[0]));

  p2s_serializer #(.DATA_BITS(8), .CLK_DIV(3), .MSB_FIRST(1)) u_b (
    .clk(clk), .rstn(rstn), .start(start_v[1]), .clr(clr_v[1]), .pdata(pdata_b),
    .busy(busy_v[1]), .done(done_v[1]), .s_clk(s_clk_v[1]), .s_data(s_data_v[1]),
    .s_latch(s_latch_v[1]), .s_clrn(s_clrn_v[1]));

  p2s_serializer #(.DATA_BITS(64), .CLK_DIV(2), .MSB_FIRST(0)) u_c (
    .clk(clk), .rstn(rstn), .start(start_v[2]), .clr(clr_v[2]), .pdata(pdata_c),
    .busy(busy_v[2]), .done(done_v[2]), .s_clk(s_clk_v[2]), .s_data(s_data_v[2]),
    .s_latch(s_latch_v[2]), .s_clrn(s_clrn_v[2]));

  int nchk = 0;
  int nerr = 0;

  int          cdiv [3] = '{1, 3, 2};
  int          rises [3], latch_cyc [3], done_cnt [3], done_at [3], since [3];
  int          clrn_low [3], busy_done_err [3], phase_err [3], low_run [3], high_run [3];
  logic [63:0] cap [3];
  logic [2:0]  prev_clk = '0, prev_busy = '0;

  // Observes the serial pins. cap collects sampled bits in send order, first
  // bit ending up in the most significant position.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy_v[i] && !prev_busy[i]) since[i] = 1;
      else                            since[i]++;
      if (s_clk_v[i] && !prev_clk[i]) begin
        rises[i]++;
        cap[i] = {cap[i][62:0], s_data_v[i]};
        if (low_run[i] != cdiv[i]) phase_err[i]++;
        high_run[i] = 0;
      end
      if (!s_clk_v[i] && prev_clk[i]) begin
        if (high_run[i] != cdiv[i]) phase_err[i]++;
        low_run[i] = 0;
      end
      if (s_clk_v[i]) high_run[i]++;
      else if (busy_v[i] && s_clrn_v[i] && !s_latch_v[i]) low_run[i]++;
      if (s_latch_v[i]) latch_cyc[i]++;
      if (!s_clrn_v[i]) clrn_low[i]++;
      if (done_v[i]) begin
        done_cnt[i]++;
        done_at[i] = since[i];
        if (busy_v[i]) busy_done_err[i]++;
      end
      prev_clk[i]  = s_clk_v[i];
      prev_busy[i] = busy_v[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon(input int i);
    @(posedge clk);
    #1;
    rises[i] = 0; latch_cyc[i] = 0; done_cnt[i] = 0; done_at[i] = 0;
    clrn_low[i] = 0; busy_done_err[i] = 0; phase_err[i] = 0;
    low_run[i] = 0; high_run[i] = 0; cap[i] = '0;
  endtask

  task automatic set_pdata(input int i, input logic [63:0] v);
    case (i)
      0:       pdata_a = v[7:0];
      1:       pdata_b = v[7:0];
      default: pdata_c = v;
    endcase
  endtask

  task automatic wait_done(input int i, input int target, input string name);
    int n = 0;
    while (done_cnt[i] < target && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, " done seen"}, 64'(done_cnt[i] >= target), 64'd1);
  endtask

  task automatic wait_rises(input int i, input int target, input string name);
    int n = 0;
    while (rises[i] < target && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, " rises reached"}, 64'(rises[i] >= target), 64'd1);
  endtask

  task automatic run_xfer(input int i, input logic [63:0] v, input string name);
    clear_mon(i);
    @(negedge clk);
    set_pdata(i, v);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    set_pdata(i, 64'd0);
    wait_done(i, 1, name);
    repeat (3) @(negedge clk);
    #1;
  endtask

  typedef struct {
    int          inst;
    logic [63:0] pdata;
    logic [63:0] exp_cap;
    int          exp_rises;
    int          exp_latch;
    int          exp_done_at;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 64'hA5, 64'hA5, 8, 1, 18};
    vecs[1] = '{0, 64'h01, 64'h80, 8, 1, 18};
    vecs[2] = '{0, 64'h36, 64'h6C, 8, 1, 18};
    vecs[3] = '{1, 64'h81, 64'h81, 8, 3, 52};
    vecs[4] = '{1, 64'h4C, 64'h4C, 8, 3, 52};
    vecs[5] = '{2, 64'h0123_4567_89AB_CDEF, 64'hF7B3_D591_E6A2_C480, 64, 2, 259};

    rstn = 1'b0;
    start_v = '0;
    clr_v = '0;
    pdata_a = '0; pdata_b = '0; pdata_c = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset idle inst%0d", i),
            64'({busy_v[i], done_v[i], s_clk_v[i], s_data_v[i], s_latch_v[i], s_clrn_v[i]}),
            64'b000001);
    rstn = 1'b1;

    for (int k = 0; k < 6; k++) begin
      int i;
      i = vecs[k].inst;
      run_xfer(i, vecs[k].pdata, $sformatf("v%0d", k));
      check($sformatf("v%0d stream", k),      cap[i], vecs[k].exp_cap);
      check($sformatf("v%0d rises", k),       64'(rises[i]), 64'(vecs[k].exp_rises));
      check($sformatf("v%0d latch cycles", k), 64'(latch_cyc[i]), 64'(vecs[k].exp_latch));
      check($sformatf("v%0d done pulses", k), 64'(done_cnt[i]), 64'd1);
      check($sformatf("v%0d done latency", k), 64'(done_at[i]), 64'(vecs[k].exp_done_at));
      check($sformatf("v%0d busy with done", k), 64'(busy_done_err[i]), 64'd0);
      check($sformatf("v%0d phase lengths", k), 64'(phase_err[i]), 64'd0);
    end

    // Chain clear on the 64-bit instance (CLK_DIV=2).
    clear_mon(2);
    @(negedge clk); clr_v[2] = 1'b1;
    @(negedge clk); clr_v[2] = 1'b0;
    wait_done(2, 1, "clear");
    repeat (4) @(negedge clk);
    #1;
    check("clear clrn low cycles", 64'(clrn_low[2]), 64'd2);
    check("clear s_clk rises",     64'(rises[2]), 64'd0);
    check("clear latch cycles",    64'(latch_cyc[2]), 64'd0);
    check("clear done pulses",     64'(done_cnt[2]), 64'd1);
    check("clear done latency",    64'(done_at[2]), 64'd3);

    // start and clr together: clear wins, start is dropped.
    clear_mon(0);
    @(negedge clk); pdata_a = 8'hFF; start_v[0] = 1'b1; clr_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0; clr_v[0] = 1'b0;
    wait_done(0, 1, "start+clr");
    repeat (10) @(negedge clk);
    #1;
    check("start+clr clrn low",    64'(clrn_low[0]), 64'd1);
    check("start+clr rises",       64'(rises[0]), 64'd0);
    check("start+clr done pulses", 64'(done_cnt[0]), 64'd1);
    check("start+clr busy after",  64'(busy_v[0]), 64'd0);

    // start re-pulsed mid-word is ignored.
    clear_mon(0);
    @(negedge clk); pdata_a = 8'hA5; start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    wait_rises(0, 3, "repulse");
    start_v[0] = 1'b1;
    @(negedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_done(0, 1, "repulse");
    repeat (5) @(negedge clk);
    #1;
    check("repulse done pulses", 64'(done_cnt[0]), 64'd1);
    check("repulse rises",       64'(rises[0]), 64'd8);
    check("repulse stream",      cap[0], 64'hA5);
    check("repulse busy after",  64'(busy_v[0]), 64'd0);

    // start held: next word accepted on the first IDLE cycle after DONE.
    clear_mon(0);
    @(negedge clk); pdata_a = 8'h0F; start_v[0] = 1'b1;
    wait_done(0, 1, "held first");
    @(negedge clk); #1;
    check("held idle gap busy", 64'(busy_v[0]), 64'd0);
    @(negedge clk); #1;
    check("held second accept busy", 64'(busy_v[0]), 64'd1);
    start_v[0] = 1'b0;
    wait_done(0, 2, "held second");
    repeat (3) @(negedge clk);
    #1;
    check("held rises",  64'(rises[0]), 64'd16);
    check("held stream", cap[0], 64'hF0F0);
    check("held done pulses", 64'(done_cnt[0]), 64'd2);

    // Reset mid-word: idle immediately, no latch or done, then a clean resend.
    clear_mon(0);
    @(negedge clk); pdata_a = 8'h36; start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    wait_rises(0, 5, "midreset");
    rstn = 1'b0;
    @(negedge clk); #1;
    check("midreset idle values",
          64'({busy_v[0], done_v[0], s_clk_v[0], s_data_v[0], s_latch_v[0], s_clrn_v[0]}),
          64'b000001);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("midreset no latch", 64'(latch_cyc[0]), 64'd0);
    check("midreset no done",  64'(done_cnt[0]), 64'd0);
    run_xfer(0, 64'h36, "resend");
    check("resend stream",       cap[0], 64'h6C);
    check("resend rises",        64'(rises[0]), 64'd8);
    check("resend done latency", 64'(done_at[0]), 64'd18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
